// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of the hazard-detection inputs and pipeline-control outputs exchanged
// between the datapath (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic       id_is_branch;
  logic [4:0] ex_rd;
  logic       ex_memread;
  logic       dmem_req;
  logic       dmem_ready;
  logic       branch_taken;
  logic       keep_pc;
  logic       keep_ifid;
  logic       keep_idex;
  logic       nop_ifid;
  logic       nop_idex;
  logic       freeze_exmem;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_branch,
    output ex_rd, ex_memread, dmem_req, dmem_ready, branch_taken,
    input  keep_pc, keep_ifid, keep_idex, nop_ifid, nop_idex, freeze_exmem
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_branch,
    input  ex_rd, ex_memread, dmem_req, dmem_ready, branch_taken,
    output keep_pc, keep_ifid, keep_idex, nop_ifid, nop_idex, freeze_exmem
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for a 5-stage pipeline: load-use bubbles (two when the
// consumer is an early-resolved branch), memory-wait freeze and redirect flushes.
module pipeline_hazard_ctrl (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave bus,
  output logic [1:0]            state_o,
  output logic [31:0]           stall_cycles,
  output logic [15:0]           flush_count
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    LUB   = 2'b01,
    MWAIT = 2'b10,
    BAD   = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q, flush_count_d;

  logic mw;
  logic lu;
  logic keep_pc, keep_ifid, keep_idex, nop_ifid, nop_idex, freeze_exmem;
  logic flush_inc;

  assign mw = bus.dmem_req & ~bus.dmem_ready;
  assign lu = bus.ex_memread & (bus.ex_rd != 5'd0) &
              ((bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd)) |
               (bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd)));

  // Priority everywhere is memory wait, then redirect, then load-use.
  always_comb begin
    state_d      = state_q;
    keep_pc      = 1'b0;
    keep_ifid    = 1'b0;
    keep_idex    = 1'b0;
    nop_ifid     = 1'b0;
    nop_idex     = 1'b0;
    freeze_exmem = 1'b0;
    flush_inc    = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mw) begin
          keep_pc      = 1'b1;
          keep_ifid    = 1'b1;
          keep_idex    = 1'b1;
          freeze_exmem = 1'b1;
          state_d      = MWAIT;
        end else if (bus.branch_taken) begin
          nop_ifid  = 1'b1;
          nop_idex  = 1'b1;
          flush_inc = 1'b1;
        end else if (lu) begin
          keep_pc   = 1'b1;
          keep_ifid = 1'b1;
          nop_idex  = 1'b1;
          state_d   = bus.id_is_branch ? LUB : RUN;
        end
      end
      LUB: begin
        // The second bubble waits until any outstanding memory access completes.
        if (mw) begin
          keep_pc      = 1'b1;
          keep_ifid    = 1'b1;
          keep_idex    = 1'b1;
          freeze_exmem = 1'b1;
        end else begin
          keep_pc   = 1'b1;
          keep_ifid = 1'b1;
          nop_idex  = 1'b1;
          state_d   = RUN;
        end
      end
      MWAIT: begin
        keep_pc      = ~bus.dmem_ready;
        keep_ifid    = ~bus.dmem_ready;
        keep_idex    = ~bus.dmem_ready;
        freeze_exmem = ~bus.dmem_ready;
        if (bus.dmem_ready) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (rst) begin
      keep_pc      = 1'b0;
      keep_ifid    = 1'b0;
      keep_idex    = 1'b0;
      nop_ifid     = 1'b0;
      nop_idex     = 1'b0;
      freeze_exmem = 1'b0;
      flush_inc    = 1'b0;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (keep_pc && (stall_cycles_q != 32'hFFFF_FFFF)) stall_cycles_d = stall_cycles_q + 32'd1;
    if (flush_inc && (flush_count_q != 16'hFFFF)) flush_count_d = flush_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 16'd0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign bus.keep_pc      = keep_pc;
  assign bus.keep_ifid    = keep_ifid;
  assign bus.keep_idex    = keep_idex;
  assign bus.nop_ifid     = nop_ifid;
  assign bus.nop_idex     = nop_idex;
  assign bus.freeze_exmem = freeze_exmem;
  assign state_o          = state_q;
  assign stall_cycles     = stall_cycles_q;
  assign flush_count      = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl; controls are checked as
// the packed vector {keep_pc, keep_ifid, keep_idex, nop_ifid, nop_idex, freeze_exmem}.
module tb_pipeline_hazard_ctrl;
  logic        clk;
  logic        rst;
  logic [1:0]  state_o;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
  int          n_checks;
  int          n_fails;

  localparam logic [5:0] C_NONE   = 6'b000000;
  localparam logic [5:0] C_LUB    = 6'b110010;
  localparam logic [5:0] C_FREEZE = 6'b111001;
  localparam logic [5:0] C_FLUSH  = 6'b000110;

  localparam logic [1:0] S_RUN   = 2'b00;
  localparam logic [1:0] S_LUB   = 2'b01;
  localparam logic [1:0] S_MWAIT = 2'b10;

  pipeline_hazard_ctrl_if hif ();

  pipeline_hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (hif.slave),
    .state_o      (state_o),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] ctrl_vec();
    return {hif.keep_pc, hif.keep_ifid, hif.keep_idex,
            hif.nop_ifid, hif.nop_idex, hif.freeze_exmem};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] rs1, input logic use1,
                               input logic [4:0] rs2, input logic use2,
                               input logic is_br, input logic [4:0] rd,
                               input logic memrd, input logic req,
                               input logic rdy, input logic bt);
    hif.id_rs1       = rs1;
    hif.id_use_rs1   = use1;
    hif.id_rs2       = rs2;
    hif.id_use_rs2   = use2;
    hif.id_is_branch = is_br;
    hif.ex_rd        = rd;
    hif.ex_memread   = memrd;
    hif.dmem_req     = req;
    hif.dmem_ready   = rdy;
    hif.branch_taken = bt;
    #1;
  endtask

  task automatic idle();
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance one rising edge and return to just after the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst      = 1'b1;
    @(negedge clk);

    // Reset held with both a memory wait and a load-use pending.
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("rst_ctrl", 32'(ctrl_vec()), 32'(C_NONE));
    step();
    checkOutput("rst_state", 32'(state_o), 32'(S_RUN));
    checkOutput("rst_stall", stall_cycles, 32'd0);
    checkOutput("rst_flush", 32'(flush_count), 32'd0);
    rst = 1'b0;

    // Single load-use bubble.
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_ctrl", 32'(ctrl_vec()), 32'(C_LUB));
    step();
    idle();
    checkOutput("lu_state", 32'(state_o), 32'(S_RUN));
    checkOutput("lu_stall", stall_cycles, 32'd1);
    checkOutput("lu_after_ctrl", 32'(ctrl_vec()), 32'(C_NONE));

    // Load-use via rs2 feeding a decode-resolved branch gives two bubbles.
    do_reset();
    applyStimulus(5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lub1_ctrl", 32'(ctrl_vec()), 32'(C_LUB));
    step();
    applyStimulus(5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("lub2_state", 32'(state_o), 32'(S_LUB));
    checkOutput("lub2_ctrl", 32'(ctrl_vec()), 32'(C_LUB));
    step();
    idle();
    checkOutput("lub_end_state", 32'(state_o), 32'(S_RUN));
    checkOutput("lub_stall", stall_cycles, 32'd2);
    checkOutput("lub_flush", 32'(flush_count), 32'd0);

    // Memory wait: ready low for three cycles, then high.
    do_reset();
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("mw1_ctrl", 32'(ctrl_vec()), 32'(C_FREEZE));
    step();
    checkOutput("mw2_state", 32'(state_o), 32'(S_MWAIT));
    applyStimulus(5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("mw2_ctrl", 32'(ctrl_vec()), 32'(C_FREEZE));
    step();
    checkOutput("mw3_ctrl", 32'(ctrl_vec()), 32'(C_FREEZE));
    step();
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("mw_ready_state", 32'(state_o), 32'(S_MWAIT));
    checkOutput("mw_ready_ctrl", 32'(ctrl_vec()), 32'(C_NONE));
    step();
    idle();
    checkOutput("mw_end_state", 32'(state_o), 32'(S_RUN));
    checkOutput("mw_stall", stall_cycles, 32'd3);

    // Redirect wins over a simultaneous load-use.
    do_reset();
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("br_ctrl", 32'(ctrl_vec()), 32'(C_FLUSH));
    step();
    idle();
    checkOutput("br_state", 32'(state_o), 32'(S_RUN));
    checkOutput("br_flush", 32'(flush_count), 32'd1);
    checkOutput("br_stall", stall_cycles, 32'd0);

    // Memory wait arriving in LUB defers the second bubble.
    do_reset();
    applyStimulus(5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("lubmw_enter", 32'(state_o), 32'(S_LUB));
    for (int i = 0; i < 2; i++) begin
      applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("lubmw_freeze%0d", i), 32'(ctrl_vec()), 32'(C_FREEZE));
      step();
      checkOutput($sformatf("lubmw_state%0d", i), 32'(state_o), 32'(S_LUB));
    end
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("lubmw_bubble", 32'(ctrl_vec()), 32'(C_LUB));
    step();
    idle();
    checkOutput("lubmw_end_state", 32'(state_o), 32'(S_RUN));
    checkOutput("lubmw_stall", stall_cycles, 32'd4);

    // Reset asserted in the middle of a memory wait.
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("rstmw_state", 32'(state_o), 32'(S_MWAIT));
    rst = 1'b1;
    #1;
    checkOutput("rstmw_ctrl", 32'(ctrl_vec()), 32'(C_NONE));
    step();
    rst = 1'b0;
    idle();
    checkOutput("rstmw_state_after", 32'(state_o), 32'(S_RUN));
    checkOutput("rstmw_stall", stall_cycles, 32'd0);

    // Register zero as load destination never stalls.
    applyStimulus(5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("x0_ctrl", 32'(ctrl_vec()), 32'(C_NONE));
    step();
    checkOutput("x0_stall", stall_cycles, 32'd0);

    // Unused source field matching the load destination is not a hazard.
    applyStimulus(5'd4, 1'b0, 5'd1, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("nouse_ctrl", 32'(ctrl_vec()), 32'(C_NONE));

    // Stall counter saturation.
    force dut.stall_cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cycles_q;
    checkOutput("sat_preset", stall_cycles, 32'hFFFF_FFFE);
    applyStimulus(5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("sat_step1", stall_cycles, 32'hFFFF_FFFF);
    step();
    step();
    checkOutput("sat_step3", stall_cycles, 32'hFFFF_FFFF);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout observed=running required=finished");
    $fatal(1, "[TB] timeout");
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 id_rs1, id_rs2  in  5 each  source registers of the instruction in IF/ID.
REQ-004 id_use_rs1, id_use_rs2  in  1 each  the matching source is actually read.
REQ-005 id_is_branch  in  1  IF/ID instruction is a conditional branch resolved early in decode.
REQ-006 ex_rd  in  5  destination of the instruction in ID/EX.
REQ-007 ex_memread  in  1  ID/EX instruction is a load.
REQ-008 dmem_req, dmem_ready  in  1 each  data-memory access in MEM and its completion.
REQ-009 branch_taken  in  1  early-branch redirect from decode (branch sits in ID/EX).
REQ-010 keep_pc, keep_ifid, keep_idex  out  1 each  hold PC, IF/ID and ID/EX (keep_idex drives decode keep).
REQ-011 nop_ifid, nop_idex  out  1 each  load a bubble into IF/ID or ID/EX (nop_idex drives decode nop).
REQ-012 freeze_exmem  out  1  hold EX/MEM and MEM/WB.
REQ-013 state_o  out  2  current FSM state.
REQ-014 stall_cycles  out  32  cycles with keep_pc=1.
REQ-015 flush_count  out  16  number of redirect flushes.

Function
REQ-016 FSM states SHALL be RUN=2'b00, LUB=2'b01, MWAIT=2'b10; 2'b11 SHALL go to RUN on the next edge, with all outputs 0.
REQ-017 Mem-wait condition mw = dmem_req & ~dmem_ready; load-use hit lu = ex_memread & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
REQ-018 All control outputs SHALL be combinational from state and current inputs (zero latency); unlisted outputs = 0.
REQ-019 Priority in every state: mw > branch_taken > lu.
REQ-020 RUN, mw: keep_pc, keep_ifid, keep_idex, freeze_exmem = 1; next MWAIT.
REQ-021 RUN, branch_taken (no mw): nop_ifid = nop_idex = 1; PC not held; flush_count += 1; next RUN; lu ignored.
REQ-022 RUN, lu (no mw, no branch_taken): keep_pc = keep_ifid = nop_idex = 1; next LUB if id_is_branch, else RUN.
REQ-023 LUB, no mw: keep_pc = keep_ifid = nop_idex = 1 (second bubble); next RUN; branch_taken ignored.
REQ-024 LUB, mw: full freeze as REQ-020; stay in LUB (second bubble deferred until memory completes).
REQ-025 MWAIT: keep_pc = keep_ifid = keep_idex = freeze_exmem = ~dmem_ready; on dmem_ready the pipeline advances that same cycle, next RUN; otherwise stay; branch_taken and lu ignored.
REQ-026 ex_rd = 0 SHALL never produce a hazard.
REQ-027 stall_cycles SHALL increment every cycle with keep_pc = 1, saturating at 32'hFFFF_FFFF; flush_count SHALL saturate at 16'hFFFF.
REQ-028 state_o SHALL equal the registered state.

Reset
REQ-029 rst = 1 at an edge: state = RUN, stall_cycles = 0, flush_count = 0, regardless of state or pending mw/lu.
REQ-030 While rst = 1, all control outputs SHALL be 0 and counters SHALL not increment.
REQ-031 The first edge after rst falls SHALL evaluate REQ-019..025 from RUN.

Verification
REQ-032 RUN, ex_memread = 1, ex_rd = 5, id_rs1 = 5, id_use_rs1 = 1, id_is_branch = 0 -> one cycle of keep_pc/keep_ifid/nop_idex = 1, then RUN; stall_cycles = 1.
REQ-033 Same as REQ-032 with id_is_branch = 1 -> two bubble cycles (RUN then LUB), stall_cycles = 2.
REQ-034 RUN, dmem_req = 1, dmem_ready low for 3 cycles then high -> 3 freeze cycles in MWAIT, outputs 0 in the ready cycle, then RUN; stall_cycles = 3.
REQ-035 RUN, branch_taken = 1 and lu true in the same cycle -> nop_ifid = nop_idex = 1, keep_pc = 0, flush_count = 1, stays RUN.
REQ-036 LUB with mw for 2 cycles -> full freeze, state stays LUB, then one bubble, then RUN; rst asserted mid-MWAIT -> RUN, counters 0.
REQ-037 ex_rd = 0, ex_memread = 1, id_rs1 = 0 -> no stall; counter saturation checked by forcing stall_cycles = 32'hFFFF_FFFE and running 3 stall cycles -> stays at 32'hFFFF_FFFF.
